// File: rtl/pc_sequencer_if.sv
// Bundle of the instruction-memory handshake and the execute-stage interface
// that connects the PC sequencer to memory and the decode/execute datapath.
interface pc_sequencer_if;
  logic        InstrReq;
  logic [63:0] InstrAddr;
  logic        InstrAck;
  logic [31:0] InstrData;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        ExecDone;
  logic        Branch;
  logic        Uncondbranch;
  logic        ALUZero;
  logic [63:0] SignExtImm64;
  logic [63:0] CurrentPC;
  logic        Halt;
  logic        Halted;
  logic        Fault;
  logic [31:0] RetiredCount;

  // Sequencer side
  modport master (
    output InstrReq, InstrAddr, Instruction, InstrValid, CurrentPC,
           Halted, Fault, RetiredCount,
    input  InstrAck, InstrData, ExecDone, Branch, Uncondbranch, ALUZero,
           SignExtImm64, Halt
  );

  // Memory / datapath side
  modport slave (
    input  InstrReq, InstrAddr, Instruction, InstrValid, CurrentPC,
           Halted, Fault, RetiredCount,
    output InstrAck, InstrData, ExecDone, Branch, Uncondbranch, ALUZero,
           SignExtImm64, Halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle LEGv8 program-counter sequencer: fetches one instruction,
// holds it while execute resolves the branch, then commits the next PC.
// Stops in HALTED on request or in FAULT on fetch timeout / misaligned target.
module pc_sequencer #(
  parameter logic [63:0] START_PC    = 64'h0,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  // Last un-acknowledged FETCH cycle count before the timeout edge
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, stateNext;
  logic [63:0] pcQ, pcNext;
  logic [31:0] instrQ, instrNext;
  logic [31:0] retiredQ, retiredNext;
  logic [7:0]  waitCnt, waitCntNext;
  logic [63:0] target;

  // LEGv8 next-PC selection; modulo-2^64 add so the PC wraps naturally
  function automatic logic [63:0] branchTarget(
    input logic [63:0]        pc,
    input logic signed [63:0] offset,
    input logic               uncond,
    input logic               br,
    input logic               zero
  );
    logic take;
    take = uncond | (br & zero);
    return take ? (pc + $unsigned(offset)) : (pc + 64'd4);
  endfunction

  assign target = branchTarget(pcQ, $signed(bus.SignExtImm64),
                               bus.Uncondbranch, bus.Branch, bus.ALUZero);

  // State and architectural registers; reset overrides every state
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= FETCH;
      pcQ      <= START_PC;
      instrQ   <= 32'd0;
      retiredQ <= 32'd0;
      waitCnt  <= 8'd0;
    end else begin
      state    <= stateNext;
      pcQ      <= pcNext;
      instrQ   <= instrNext;
      retiredQ <= retiredNext;
      waitCnt  <= waitCntNext;
    end
  end

  // Next-state, fetch latch, timeout counting and retirement
  always_comb begin
    stateNext   = state;
    pcNext      = pcQ;
    instrNext   = instrQ;
    retiredNext = retiredQ;
    waitCntNext = waitCnt;
    case (state)
      FETCH: begin
        if (bus.InstrAck) begin
          instrNext   = bus.InstrData;
          waitCntNext = 8'd0;
          stateNext   = EXEC;
        end else if (waitCnt == ACK_LAST) begin
          waitCntNext = 8'd0;
          stateNext   = FAULT;
        end else begin
          waitCntNext = waitCnt + 8'd1;
        end
      end
      EXEC: begin
        if (bus.ExecDone) begin
          if (target[1:0] == 2'b00) begin
            pcNext      = target;
            retiredNext = retiredQ + 32'd1;
            stateNext   = bus.Halt ? HALTED : FETCH;
          end else begin
            stateNext = FAULT;
          end
        end
      end
      default: begin
        stateNext = state;
      end
    endcase
  end

  assign bus.InstrReq     = (state == FETCH);
  assign bus.InstrValid   = (state == EXEC);
  assign bus.Halted       = (state == HALTED);
  assign bus.Fault        = (state == FAULT);
  assign bus.InstrAddr    = pcQ;
  assign bus.CurrentPC    = pcQ;
  assign bus.Instruction  = instrQ;
  assign bus.RetiredCount = retiredQ;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the LEGv8 processor. It owns the PC register and drives the instruction-memory request/acknowledge handshake. It holds each fetched instruction stable while the execute stage works, then commits the next PC using the standard LEGv8 next-PC rules (unconditional branch, CBZ-style conditional branch, or PC+4). It also provides halt, misalignment fault, fetch-timeout fault and a retired-instruction counter. It sits between instruction memory and the decode/execute datapath, replacing the free-running PC register of the single-cycle design.

## Interface
- START_PC, 64'h0: PC value loaded on reset.
- ACK_TIMEOUT, 16: consecutive un-acknowledged FETCH cycles before fault. Legal range 1..255.

- CLK  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- InstrReq  out  1  fetch request to instruction memory
- InstrAddr  out  64  fetch address; equals CurrentPC
- InstrAck  in  1  memory acknowledge; InstrData is valid in the same cycle
- InstrData  in  32  instruction word from memory
- Instruction  out  32  latched instruction for decode
- InstrValid  out  1  Instruction is valid and executing
- ExecDone  in  1  execute stage has resolved Branch/Uncondbranch/ALUZero/SignExtImm64
- Branch  in  1  conditional branch (taken when ALUZero=1)
- Uncondbranch  in  1  unconditional branch
- ALUZero  in  1  ALU zero flag
- SignExtImm64  in  64  branch byte offset, already sign-extended and shifted
- CurrentPC  out  64  architectural PC
- Halt  in  1  stop request, sampled at retirement
- Halted  out  1  sequencer stopped cleanly
- Fault  out  1  sequencer stopped on error
- RetiredCount  out  32  instructions committed since reset

## Operation
- FSM states: FETCH, EXEC, HALTED, FAULT.
- Reset (sync, highest priority in every state) sets:
  - state=FETCH, CurrentPC=START_PC, Instruction=0, RetiredCount=0, timeout counter=0.
  - Resulting outputs: InstrReq=1, InstrValid=0, Halted=0, Fault=0.
- Outputs decode from state: InstrReq=(FETCH), InstrValid=(EXEC), Halted=(HALTED), Fault=(FAULT). InstrAddr=CurrentPC at all times.
- FETCH:
  - On an edge with InstrAck=1: Instruction<=InstrData, counter<=0, go to EXEC.
  - Otherwise counter increments. When counter reaches ACK_TIMEOUT, go to FAULT.
- EXEC: wait for ExecDone=1, then compute the target:
  - Uncondbranch=1: target = CurrentPC + SignExtImm64 (Branch/ALUZero ignored).
  - else Branch=1 and ALUZero=1: target = CurrentPC + SignExtImm64.
  - else: target = CurrentPC + 4.
- Retirement, when target[1:0]==0:
  - CurrentPC<=target, RetiredCount+1.
  - Next state is HALTED if Halt=1, else FETCH.
- Misaligned target (target[1:0]!=0): go to FAULT; CurrentPC and RetiredCount are unchanged.
- HALTED and FAULT are sticky until Reset. All inputs are ignored in these states.
- Arithmetic: 64-bit modulo addition, so the PC wraps at 2^64 (e.g. 64'hFFFF_FFFF_FFFF_FFFC+4 = 0). RetiredCount wraps at 2^32.
- InstrAck outside FETCH and ExecDone outside EXEC are ignored.
- Halt is sampled only at the retirement edge.

## Timing
- All state, PC, Instruction, counter and count registers update on the rising edge of CLK.
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then EXEC with ExecDone=1.
- InstrReq rises the cycle after reset deasserts. Instruction is valid from the cycle after the acknowledging edge, and stays stable throughout EXEC.
- CurrentPC changes exactly one cycle after ExecDone is sampled. The same edge asserts InstrReq at the new address, so there are no bubbles.
- Fetch timeout: FAULT is entered on the edge ending the ACK_TIMEOUT-th consecutive FETCH cycle without ack. If InstrAck is high on that same edge, the ack wins and the state goes to EXEC.
- Reset asserted mid-FETCH or mid-EXEC aborts the instruction: there is no retirement and Instruction is cleared. Any pending memory response after reset is ignored unless it arrives in the new FETCH.

## Test plan
- Reset with START_PC=0x100, immediate acks, ExecDone each EXEC, no branches. Required: InstrAddr sequence 0x100, 0x104, 0x108; RetiredCount=3 after 6 cycles.
- Taken CBZ at PC=0x200 (Branch=1, ALUZero=1, SignExtImm64=-8): CurrentPC becomes 0x1F8. The same branch with ALUZero=0 gives 0x204. With Uncondbranch=1, Branch=0 and offset 0x40, CurrentPC becomes 0x240.
- Ack delayed 3 cycles with ACK_TIMEOUT=4: instruction is latched normally and Fault stays 0. No ack with ACK_TIMEOUT=4: Fault=1 after exactly 4 FETCH cycles and CurrentPC is unchanged. Ack on the 4th cycle: state goes to EXEC.
- Branch target misaligned (PC=0x300, offset 0x6): Fault=1, CurrentPC stays 0x300, RetiredCount is not incremented. Later acks and ExecDone have no effect until Reset.
- Halt=1 at the 2nd retirement: Halted=1, CurrentPC=START_PC+8, RetiredCount=2, InstrReq=0 held. Reset then restarts from START_PC.
- Wrap and reset: PC 64'hFFFF_FFFF_FFFF_FFFC with a fall-through instruction gives CurrentPC=0. Reset asserted during EXEC clears Instruction, with InstrValid=0 and RetiredCount=0 on the next cycle.
